// File: rtl/tmds_decoder.sv
// TMDS channel decoder with word-alignment search and bitslip control.
// Latency: 1 clk from TMDS to VD/CD/VDE/locked/bitslip (all outputs registered).
// Backpressure: none; one word is accepted every clk and the output cannot stall.
//
// Ports:
//   clk           pixel clock, one 10-bit TMDS word per cycle
//   rst           asynchronous active-high reset
//   TMDS[9:0]     parallel word from the deserializer, bit 0 first on the wire
//   VD[7:0]       decoded video data (0 outside data periods or when unlocked)
//   CD[1:0]       decoded control bits {C1,C0}; held during data periods
//   VDE           video data enable
//   locked        word alignment achieved
//   bitslip       one-cycle request to the deserializer to shift by 1 bit
//   lock_loss_cnt saturating count of LOCKED->SEARCH transitions
//                 (present only when TMDS_LOCK_STATS_EN is defined)
module tmds_decoder #(
  parameter int CTRL_RUN     = 8,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int SLIP_WAIT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  TMDS,
  output logic [7:0]  VD,
  output logic [1:0]  CD,
  output logic        VDE,
  output logic        locked,
  output logic        bitslip
`ifdef TMDS_LOCK_STATS_EN
  ,
  output logic [15:0] lock_loss_cnt
`endif
);

  localparam int RUN_W = $clog2(CTRL_RUN + 1);
  localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int WT_W  = $clog2(SLIP_WAIT + 1);

  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(CTRL_RUN - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [WT_W-1:0]  WT_LAST  = WT_W'(SLIP_WAIT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH    = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  state_t           r_state;
  logic [RUN_W-1:0] r_run;
  logic [TO_W-1:0]  r_to;
  logic [WT_W-1:0]  r_wait;
  logic [7:0]       r_vd;
  logic [1:0]       r_cd;
  logic             r_vde;
  logic             r_locked;
  logic             r_bitslip;
`ifdef TMDS_LOCK_STATS_EN
  logic [15:0]      r_loss_cnt;
`endif

  logic             w_is_ctrl;
  logic [1:0]       w_ctrl_cd;
  logic [7:0]       w_q;
  logic [7:0]       w_vd;
  logic             w_run_done;
  logic             w_to_hit;
  logic             w_lock_nxt;

  // Control token classification
  always_comb begin
    w_is_ctrl = 1'b1;
    w_ctrl_cd = 2'b00;
    case (TMDS)
      10'b1101010100: w_ctrl_cd = 2'b00;
      10'b0010101011: w_ctrl_cd = 2'b01;
      10'b0101010100: w_ctrl_cd = 2'b10;
      10'b1010101011: w_ctrl_cd = 2'b11;
      default:        w_is_ctrl = 1'b0;
    endcase
  end

  // Data decode: undo the optional inversion (bit 9), then undo the
  // XOR (bit 8 = 1) or XNOR (bit 8 = 0) transition chain.
  always_comb begin
    w_q     = TMDS[9] ? ~TMDS[7:0] : TMDS[7:0];
    w_vd    = 8'h00;
    w_vd[0] = w_q[0];
    for (int i = 1; i < 8; i++) begin
      w_vd[i] = TMDS[8] ? (w_q[i] ^ w_q[i-1]) : ~(w_q[i] ^ w_q[i-1]);
    end
  end

  assign w_run_done = w_is_ctrl && (r_run == RUN_LAST);
  assign w_to_hit   = (r_to == TO_LAST);

  // Lock state after this edge. The outputs for the current word are gated
  // with it so that locked and the decoded word appear on the same cycle:
  // the token completing a run is already presented decoded, and the word
  // that exhausts the timeout while locked is already forced to zero.
  always_comb begin
    w_lock_nxt = 1'b0;
    case (r_state)
      ST_SEARCH: w_lock_nxt = w_run_done;
      ST_LOCKED: w_lock_nxt = !(!w_is_ctrl && w_to_hit);
      default:   w_lock_nxt = 1'b0;
    endcase
  end

  // Alignment FSM and registered outputs. Every counter increment sits behind
  // a compare against its terminal value, so no counter can wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_SEARCH;
      r_run      <= '0;
      r_to       <= '0;
      r_wait     <= '0;
      r_vd       <= 8'h00;
      r_cd       <= 2'b00;
      r_vde      <= 1'b0;
      r_locked   <= 1'b0;
      r_bitslip  <= 1'b0;
`ifdef TMDS_LOCK_STATS_EN
      r_loss_cnt <= 16'h0000;
`endif
    end else begin
      r_bitslip <= 1'b0;

      case (r_state)
        ST_SEARCH: begin
          if (w_run_done) begin
            // Lock takes priority over a coincident timeout.
            r_state <= ST_LOCKED;
            r_run   <= '0;
            r_to    <= '0;
          end else if (w_to_hit) begin
            r_state   <= ST_SLIP_WAIT;
            r_bitslip <= 1'b1;
            r_run     <= '0;
            r_to      <= '0;
            r_wait    <= '0;
          end else if (w_is_ctrl) begin
            r_run <= r_run + 1'b1;
            r_to  <= '0;
          end else begin
            r_run <= '0;
            r_to  <= r_to + 1'b1;
          end
        end

        ST_SLIP_WAIT: begin
          // Input is ignored while the deserializer settles.
          if (r_wait == WT_LAST) begin
            r_state <= ST_SEARCH;
            r_run   <= '0;
            r_to    <= '0;
            r_wait  <= '0;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end

        ST_LOCKED: begin
          if (w_is_ctrl) begin
            r_to <= '0;
          end else if (w_to_hit) begin
            // Lock loss goes straight back to SEARCH without a bitslip.
            r_state <= ST_SEARCH;
            r_run   <= '0;
            r_to    <= '0;
`ifdef TMDS_LOCK_STATS_EN
            if (r_loss_cnt != 16'hFFFF) begin
              r_loss_cnt <= r_loss_cnt + 16'h0001;
            end
`endif
          end else begin
            r_to <= r_to + 1'b1;
          end
        end

        default: begin
          r_state <= ST_SEARCH;
          r_run   <= '0;
          r_to    <= '0;
          r_wait  <= '0;
        end
      endcase

      r_locked <= w_lock_nxt;
      if (!w_lock_nxt) begin
        r_vd  <= 8'h00;
        r_cd  <= 2'b00;
        r_vde <= 1'b0;
      end else if (w_is_ctrl) begin
        r_vd  <= 8'h00;
        r_cd  <= w_ctrl_cd;
        r_vde <= 1'b0;
      end else begin
        // CD keeps the last control value through the data period.
        r_vd  <= w_vd;
        r_vde <= 1'b1;
      end
    end
  end

  assign VD      = r_vd;
  assign CD      = r_cd;
  assign VDE     = r_vde;
  assign locked  = r_locked;
  assign bitslip = r_bitslip;
`ifdef TMDS_LOCK_STATS_EN
  assign lock_loss_cnt = r_loss_cnt;
`endif

endmodule
